// File: rtl/prv32_muldiv_if.sv
// Request/response bundle between the execute-stage control path and the
// iterative RV32M multiply/divide unit.
interface prv32_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] r;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, r
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, r
  );
endinterface

// File: rtl/prv32_muldiv.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign correction applied in a final SIGN cycle.
module prv32_muldiv #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  prv32_muldiv_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0] opnd;
  logic [2:0]      op_q;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] r_q;
  logic            busy_q, done_q;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, overflow, special, accept;
  logic [XLEN-1:0] special_r;

  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_step, div_step, step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.op)
      OP_MULH, OP_DIV, OP_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULHSU:               a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_signed & bus.a[XLEN-1];
  assign b_neg = b_signed & bus.b[XLEN-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  // Divide-by-zero and signed overflow are answered without iterating.
  assign div_by_zero = bus.op[2] && (bus.b == '0);
  assign overflow    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                       (bus.a == MIN_INT) && (bus.b == '1);
  assign special     = div_by_zero | overflow;
  assign special_r   = div_by_zero ? (bus.op[1] ? bus.a : '1)
                                   : (bus.op[1] ? '0 : MIN_INT);
  assign accept      = (state == IDLE) && bus.start && !bus.flush;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step  = {mul_sum, acc[XLEN-1:1]};
  assign div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
  assign div_step  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign step      = op_q[2] ? div_step : mul_step;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:                       result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = special ? DONE : CALC;
      CALC: if (bus.flush) next_state = IDLE;
            else if (cnt == CW'(XLEN-1)) next_state = SIGN;
      SIGN: next_state = bus.flush ? IDLE : DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      r_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (next_state != IDLE);
      done_q <= (next_state == DONE);
      case (state)
        IDLE: if (accept) begin
          op_q  <= bus.op;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          acc   <= {{XLEN{1'b0}}, a_mag};
          opnd  <= b_mag;
          cnt   <= '0;
          if (special) r_q <= special_r;
        end
        CALC: if (!bus.flush) begin
          acc <= step;
          cnt <= cnt + 1'b1;
        end
        SIGN: if (!bus.flush) r_q <= result;
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.r    = r_q;

endmodule

// File: tb/tb_prv32_muldiv.sv
// Directed self-checking bench for prv32_muldiv: arithmetic vectors, special
// cases, ignored start, flush, and asynchronous reset mid-operation.
module tb_prv32_muldiv;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  prv32_muldiv_if bus ();

  prv32_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request; returns right after the accepting edge, operands scrambled.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Count negedges until done (bounded); cycle 1 is the cycle right after the accepting edge.
  task automatic wait_done(output int cyc, output bit seen, output int busy_low);
    cyc = 0; seen = 1'b0; busy_low = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!bus.busy) busy_low++;
      if (bus.done) seen = 1'b1;
    end
  endtask

  task automatic watch(input int n, output int dones, output int busies);
    dones = 0; busies = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.busy) busies++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_r, input int exp_cyc);
    int cyc, busy_low;
    bit seen;
    issue(o, x, y);
    wait_done(cyc, seen, busy_low);
    check({tag, "/done_seen"}, 32'(seen), 32'd1);
    check({tag, "/latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "/r"}, bus.r, exp_r);
    check({tag, "/busy_held"}, 32'(busy_low), 32'd0);
    @(negedge clk);
    check({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "/busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cyc, busy_low, dones, busies;
    bit seen;
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    repeat (3) @(negedge clk);
    check("reset/busy", 32'(bus.busy), 32'd0);
    check("reset/done", 32'(bus.done), 32'd0);
    check("reset/r", bus.r, 32'd0);
    rst = 1'b1;

    // Normal ops: done 34 negedges after accept (cycle after E33); specials 1.
    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       34);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        34);
    run_op("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("div_mix", 3'b100, 32'd1000,    32'hFFFFFFF6, 32'hFFFFFF9C, 34);

    // A second start while busy must be dropped.
    issue(3'b100, 32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b101;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, seen, busy_low);
    check("ignore/done_seen", 32'(seen), 32'd1);
    check("ignore/r", bus.r, 32'd100);
    watch(40, dones, busies);
    check("ignore/no_second_done", 32'(dones), 32'd0);
    check("ignore/no_second_busy", 32'(busies), 32'd0);

    // Flush at cycle 15 of a MULHU: busy drops next cycle, r keeps 100.
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (14) @(negedge clk);
    check("flush/busy_before", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush/busy_after", 32'(bus.busy), 32'd0);
    check("flush/done_after", 32'(bus.done), 32'd0);
    watch(40, dones, busies);
    check("flush/no_done", 32'(dones), 32'd0);
    check("flush/r_kept", bus.r, 32'd100);

    run_op("restart", 3'b101, 32'd100, 32'd7, 32'd14, 34);

    // start together with flush in IDLE is refused.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 3'b101;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("startflush/busy", 32'(bus.busy), 32'd0);
    watch(40, dones, busies);
    check("startflush/no_done", 32'(dones), 32'd0);
    check("startflush/r_kept", bus.r, 32'd14);

    // Asynchronous reset mid-MUL, between clock edges.
    issue(3'b000, 32'd3, 32'd5);
    repeat (20) @(negedge clk);
    check("arst/busy_before", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst/busy", 32'(bus.busy), 32'd0);
    check("arst/done", 32'(bus.done), 32'd0);
    check("arst/r", bus.r, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    watch(20, dones, busies);
    check("arst/no_done", 32'(dones), 32'd0);
    run_op("post_reset", 3'b000, 32'd3, 32'd5, 32'd15, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
